// File: rtl/pea_pkg.sv
// Shared types and sizing constants for the processing-element array blocks.
package pea_pkg;

  localparam int unsigned N_BITS    = 32;
  localparam int unsigned N_DIV_REQ = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } div_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first asserted request at or above ptr, wrapping at N_REQ.
module rr_arbiter #(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  input  logic             en,
  output logic [N_REQ-1:0] gnt_onehot,
  output logic [IDW-1:0]   gnt_idx
);

  int unsigned     w_pos;
  logic [IDW-1:0]  w_idx;
  logic            w_found;

  // Scan from ptr upward; the first valid request wins the grant.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    w_found    = 1'b0;
    w_pos      = 0;
    w_idx      = '0;
    if (en) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        w_pos = 32'(ptr) + k;
        if (w_pos >= N_REQ) w_pos = w_pos - N_REQ;
        w_idx = IDW'(w_pos);
        if (!w_found && req[w_idx]) begin
          gnt_onehot[w_idx] = 1'b1;
          gnt_idx           = w_idx;
          w_found           = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/s_div_arbiter.sv
// Shares one divider among N_REQ PEs: round-robin grant, single transaction in
// flight, divide-by-zero bypass, global stall and kernel-end flush.
module s_div_arbiter #(
  parameter int unsigned N_REQ  = pea_pkg::N_DIV_REQ,
  parameter int unsigned N_BITS = pea_pkg::N_BITS
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         mage_done_i,
  input  logic                         pea_ready_i,
  input  logic [N_REQ-1:0]             req_valid_i,
  input  logic [N_REQ-1:0][N_BITS-1:0] req_a_i,
  input  logic [N_REQ-1:0][N_BITS-1:0] req_b_i,
  input  logic [N_REQ-1:0]             req_signed_i,
  output logic [N_REQ-1:0]             req_ready_o,
  output logic [N_REQ-1:0]             resp_valid_o,
  input  logic [N_REQ-1:0]             resp_ready_i,
  output logic [N_BITS-1:0]            resp_q_o,
  output logic [N_BITS-1:0]            resp_r_o,
  output logic                         div_start_o,
  output logic                         div_abort_o,
  output logic [N_BITS-1:0]            div_a_o,
  output logic [N_BITS-1:0]            div_b_o,
  output logic                         div_signed_o,
  input  logic                         div_done_i,
  input  logic [N_BITS-1:0]            div_q_i,
  input  logic [N_BITS-1:0]            div_r_i
);

  import pea_pkg::*;

  localparam int unsigned IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  div_arb_state_t    r_state, w_state_nxt;
  logic [IDW-1:0]    r_ptr, r_id, w_gnt_idx, w_ptr_nxt;
  logic [N_REQ-1:0]  w_gnt_onehot;
  logic              w_grant_en, w_grant, w_b_zero, w_resp_hs;
  logic [N_BITS-1:0] r_a, r_b, r_q, r_r, w_a_sel, w_b_sel;
  logic              r_signed, w_signed_sel;

  // Grants only happen in IDLE, unstalled, outside reset and flush.
  assign w_grant_en   = (r_state == IDLE) && pea_ready_i && !mage_done_i && !rst_i;
  assign w_grant      = |w_gnt_onehot;
  assign w_a_sel      = req_a_i[w_gnt_idx];
  assign w_b_sel      = req_b_i[w_gnt_idx];
  assign w_signed_sel = req_signed_i[w_gnt_idx];
  assign w_b_zero     = (w_b_sel == '0);
  assign w_resp_hs    = resp_ready_i[r_id] && pea_ready_i;
  assign w_ptr_nxt    = (r_id == IDW'(N_REQ - 1)) ? '0 : r_id + 1'b1;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req        (req_valid_i),
    .ptr        (r_ptr),
    .en         (w_grant_en),
    .gnt_onehot (w_gnt_onehot),
    .gnt_idx    (w_gnt_idx)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state: flush overrides everything; done is only honoured in WAIT.
  always_comb begin
    w_state_nxt = r_state;
    if (mage_done_i) begin
      w_state_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE:    if (w_grant)     w_state_nxt = w_b_zero ? RESP : ISSUE;
        ISSUE:   if (pea_ready_i) w_state_nxt = WAIT;
        WAIT:    if (div_done_i)  w_state_nxt = RESP;
        RESP:    if (w_resp_hs)   w_state_nxt = IDLE;
        default:                  w_state_nxt = IDLE;
      endcase
    end
  end

  // Handshake and divider control decoded from state; all forced low in reset.
  always_comb begin
    req_ready_o  = w_gnt_onehot;
    resp_valid_o = '0;
    div_start_o  = 1'b0;
    div_abort_o  = 1'b0;
    if (!rst_i) begin
      if (r_state == RESP) resp_valid_o[r_id] = 1'b1;
      div_start_o = (r_state == ISSUE) && pea_ready_i && !mage_done_i;
      div_abort_o = ((r_state == ISSUE) || (r_state == WAIT)) && mage_done_i;
    end
  end

  // Operand/result latches and round-robin pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i || mage_done_i) begin
      r_ptr    <= '0;
      r_id     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_q      <= '0;
      r_r      <= '0;
    end else begin
      unique case (r_state)
        IDLE: if (w_grant) begin
          r_id     <= w_gnt_idx;
          r_a      <= w_a_sel;
          r_b      <= w_b_sel;
          r_signed <= w_signed_sel;
          if (w_b_zero) begin
            r_q <= '1;
            r_r <= w_a_sel;
          end
        end
        WAIT: if (div_done_i) begin
          r_q <= div_q_i;
          r_r <= div_r_i;
        end
        RESP: if (w_resp_hs) r_ptr <= w_ptr_nxt;
        default: ;
      endcase
    end
  end

  assign div_a_o      = r_a;
  assign div_b_o      = r_b;
  assign div_signed_o = r_signed;
  assign resp_q_o     = r_q;
  assign resp_r_o     = r_r;

endmodule

// File: tb/tb_s_div_arbiter.sv
// Bench for s_div_arbiter: transaction-level model plus a behavioural divider.
module tb_s_div_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, mage, pea;
  logic [N-1:0]         req_valid, req_ready, resp_valid, resp_ready, req_sgn;
  logic [N-1:0][W-1:0]  req_a, req_b;
  logic [W-1:0]         resp_q, resp_r, div_a, div_b, div_q, div_r;
  logic                 div_start, div_abort, div_sgn, div_done;

  s_div_arbiter #(.N_REQ(N), .N_BITS(W)) dut (
    .clk_i(clk), .rst_i(rst), .mage_done_i(mage), .pea_ready_i(pea),
    .req_valid_i(req_valid), .req_a_i(req_a), .req_b_i(req_b),
    .req_signed_i(req_sgn), .req_ready_o(req_ready), .resp_valid_o(resp_valid),
    .resp_ready_i(resp_ready), .resp_q_o(resp_q), .resp_r_o(resp_r),
    .div_start_o(div_start), .div_abort_o(div_abort), .div_a_o(div_a),
    .div_b_o(div_b), .div_signed_o(div_sgn), .div_done_i(div_done),
    .div_q_i(div_q), .div_r_i(div_r)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Transaction-level reference: one optional in-flight transaction.
  bit          m_act, m_started, m_res;
  int          m_id, m_ptr;
  logic [W-1:0] m_a, m_b, m_q, m_r;
  logic        m_s;

  // Behavioural divider.
  int          dv_cnt, dv_lat;
  logic [W-1:0] dv_a, dv_b;
  logic        dv_s;

  // Observation logs for literal checks.
  int          g_ids[$];
  int          g_cyc[$];
  int          start_n, start_cyc_last, abort_n, abort_cyc_last, resp_first;
  logic        start_sgn_last;
  logic [N-1:0] resp_v_first;
  logic [W-1:0] resp_q_first, resp_r_first;
  logic [N-1:0] rv_log [0:8191];

  function automatic void divmodel(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic s, output logic [W-1:0] q,
                                   output logic [W-1:0] r);
    logic signed [W-1:0] sa, sb;
    sa = a; sb = b;
    if (b == '0) begin q = '1; r = a; end
    else if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin q = a; r = '0; end
      else begin q = sa / sb; r = sa % sb; end
    end else begin q = a / b; r = a % b; end
  endfunction

  function automatic void model_clear();
    m_act = 0; m_started = 0; m_res = 0; m_id = 0; m_ptr = 0;
    m_a = '0; m_b = '0; m_q = '0; m_r = '0; m_s = 1'b0;
  endfunction

  function automatic void model_step();
    int g;
    logic [N-1:0] e_rr, e_rv;
    bit issuing, waiting, e_start, e_abort;
    g = -1;
    issuing = m_act && !m_started && !m_res;
    waiting = m_act && m_started && !m_res;
    if (!rst && !m_act && pea && !mage)
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (g < 0 && req_valid[j]) g = j;
      end
    e_rr    = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    e_rv    = (!rst && m_res) ? (4'b0001 << m_id) : 4'b0000;
    e_start = !rst && issuing && pea && !mage;
    e_abort = !rst && (issuing || waiting) && mage;
    chk("req_ready",  64'(req_ready),  64'(e_rr));
    chk("resp_valid", 64'(resp_valid), 64'(e_rv));
    chk("div_start",  64'(div_start),  64'(e_start));
    chk("div_abort",  64'(div_abort),  64'(e_abort));
    chk("div_a",      64'(div_a),      64'(m_a));
    chk("div_b",      64'(div_b),      64'(m_b));
    chk("div_signed", 64'(div_sgn),    64'(m_s));
    chk("resp_q",     64'(resp_q),     64'(m_q));
    chk("resp_r",     64'(resp_r),     64'(m_r));
    if (rst || mage) model_clear();
    else if (!m_act) begin
      if (g >= 0) begin
        m_act = 1; m_id = g; m_a = req_a[g]; m_b = req_b[g]; m_s = req_sgn[g];
        if (req_b[g] == '0) begin m_res = 1; m_q = '1; m_r = req_a[g]; end
      end
    end else if (issuing) begin
      if (pea) m_started = 1;
    end else if (waiting) begin
      if (div_done) begin m_res = 1; m_q = div_q; m_r = div_r; end
    end else if (resp_ready[m_id] && pea) begin
      m_act = 0; m_started = 0; m_res = 0; m_ptr = (m_id + 1) % N;
    end
  endfunction

  function automatic void log_outputs();
    for (int i = 0; i < N; i++)
      if (req_ready[i]) begin g_ids.push_back(i); g_cyc.push_back(cyc); end
    if (div_start) begin start_n++; start_cyc_last = cyc; start_sgn_last = div_sgn; end
    if (div_abort) begin abort_n++; abort_cyc_last = cyc; end
    if (resp_valid != '0 && resp_first < 0) begin
      resp_first = cyc; resp_v_first = resp_valid; resp_q_first = resp_q; resp_r_first = resp_r;
    end
    if (cyc >= 0 && cyc < 8192) rv_log[cyc] = resp_valid;
  endfunction

  function automatic logic [N-1:0] rv_at(int c);
    if (c >= 0 && c < 8192) return rv_log[c];
    return 4'b1111;
  endfunction

  function automatic void clear_logs();
    g_ids.delete(); g_cyc.delete();
    start_n = 0; start_cyc_last = -1; abort_n = 0; abort_cyc_last = -1;
    resp_first = -1; start_sgn_last = 1'b0;
    resp_v_first = '0; resp_q_first = '0; resp_r_first = '0;
  endfunction

  task automatic tick();
    @(negedge clk);
    model_step();
    log_outputs();
    if (rst) dv_cnt = 0;
    else if (div_start) begin dv_cnt = dv_lat; dv_a = div_a; dv_b = div_b; dv_s = div_sgn; end
    @(posedge clk);
    #1;
    cyc++;
    div_done = 1'b0; div_q = $urandom; div_r = $urandom;
    if (dv_cnt > 0) begin
      dv_cnt--;
      if (dv_cnt == 0) begin div_done = 1'b1; divmodel(dv_a, dv_b, dv_s, div_q, div_r); end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; mage = 1'b0; req_valid = '0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic run_until_resp(int max);
    int n;
    n = 0;
    while (resp_first < 0 && n < max) begin tick(); n++; end
  endtask

  function automatic int gid(int k);
    if (k < g_ids.size()) return g_ids[k];
    return -1;
  endfunction

  function automatic int gcy(int k);
    if (k < g_cyc.size()) return g_cyc[k];
    return -1;
  endfunction

  initial begin
    int base;
    rst = 1'b1; mage = 1'b0; pea = 1'b1; req_valid = '0; resp_ready = '1;
    req_a = '0; req_b = '0; req_sgn = '0;
    div_done = 1'b0; div_q = '0; div_r = '0; dv_cnt = 0; dv_lat = 4;
    dv_a = '0; dv_b = '0; dv_s = 1'b0;
    model_clear(); clear_logs();
    for (int i = 0; i < 8192; i++) rv_log[i] = '0;
    @(posedge clk); #1;

    // Reset state
    do_reset();
    #1;
    chk("rst_req_ready",  64'(req_ready),  64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_div_start",  64'(div_start),  64'(0));
    chk("rst_div_a",      64'(div_a),      64'(0));
    chk("rst_resp_q",     64'(resp_q),     64'(0));

    // Single request: PE1 100/7, divider latency 4
    clear_logs(); base = cyc; dv_lat = 4;
    req_a[1] = 100; req_b[1] = 7; req_sgn = '0; req_valid = 4'b0010;
    tick(); req_valid = '0;
    run_until_resp(20);
    chk("single_grant_cyc", 64'(gcy(0) - base), 64'(0));
    chk("single_grant_id",  64'(gid(0)), 64'(1));
    chk("single_start_cyc", 64'(start_cyc_last - base), 64'(1));
    chk("single_resp_cyc",  64'(resp_first - base), 64'(6));
    chk("single_resp_v",    64'(resp_v_first), 64'(4'b0010));
    chk("single_q",         64'(resp_q_first), 64'(14));
    chk("single_r",         64'(resp_r_first), 64'(2));

    // Contention: all PEs request from reset
    do_reset(); clear_logs(); dv_lat = 2;
    for (int i = 0; i < N; i++) begin req_a[i] = 1000 + i; req_b[i] = 3 + i; end
    req_valid = '1;
    for (int n = 0; n < 200 && g_ids.size() < 5; n++) tick();
    req_valid = '0;
    chk("rr_0", 64'(gid(0)), 64'(0));
    chk("rr_1", 64'(gid(1)), 64'(1));
    chk("rr_2", 64'(gid(2)), 64'(2));
    chk("rr_3", 64'(gid(3)), 64'(3));
    chk("rr_4", 64'(gid(4)), 64'(0));

    // Divide by zero: PE2 55/0
    do_reset(); clear_logs(); base = cyc;
    req_a[2] = 55; req_b[2] = 0; req_valid = 4'b0100;
    tick(); req_valid = '0;
    run_until_resp(10);
    chk("dz_grant_cyc", 64'(gcy(0) - base), 64'(0));
    chk("dz_resp_cyc",  64'(resp_first - base), 64'(1));
    chk("dz_q",         64'(resp_q_first), 64'(32'hFFFF_FFFF));
    chk("dz_r",         64'(resp_r_first), 64'(55));
    chk("dz_no_start",  64'(start_n), 64'(0));

    // Stall in ISSUE (cycles 1..3) and in RESP (cycles 7..9)
    do_reset(); clear_logs(); base = cyc; dv_lat = 2;
    req_a[0] = 20; req_b[0] = 3;
    for (int c = 0; c < 15; c++) begin
      pea = !((c >= 1 && c <= 3) || (c >= 7 && c <= 9));
      req_valid = (c == 0) ? 4'b0001 : 4'b0000;
      tick();
    end
    pea = 1'b1;
    chk("stall_start_cyc", 64'(start_cyc_last - base), 64'(4));
    chk("stall_start_n",   64'(start_n), 64'(1));
    chk("stall_resp_cyc",  64'(resp_first - base), 64'(7));
    chk("stall_rv_9",      64'(rv_at(base + 9)),  64'(4'b0001));
    chk("stall_rv_10",     64'(rv_at(base + 10)), 64'(4'b0001));
    chk("stall_rv_11",     64'(rv_at(base + 11)), 64'(4'b0000));

    // Flush during WAIT after moving the pointer to 3
    do_reset(); clear_logs(); dv_lat = 2;
    req_a[2] = 30; req_b[2] = 5; req_valid = 4'b0100;
    tick(); req_valid = '0;
    run_until_resp(20);
    clear_logs(); base = cyc; dv_lat = 6;
    req_a[1] = 9; req_b[1] = 2; req_a[3] = 77; req_b[3] = 4; req_valid = 4'b0010;
    tick(); req_valid = '0;
    tick(); tick();
    mage = 1'b1; tick(); mage = 1'b0;
    repeat (9) tick();
    req_valid = 4'b1010;
    tick(); req_valid = '0;
    chk("flush_abort_n",   64'(abort_n), 64'(1));
    chk("flush_abort_cyc", 64'(abort_cyc_last - base), 64'(3));
    chk("flush_no_resp",   64'(resp_first), 64'(-1));
    chk("flush_ptr0_gnt",  64'(gid(1)), 64'(1));
    dv_lat = 2;
    run_until_resp(20);

    // Signed: PE3 -100/7
    do_reset(); clear_logs(); dv_lat = 3;
    req_a[3] = 32'hFFFF_FF9C; req_b[3] = 7; req_sgn = 4'b1000; req_valid = 4'b1000;
    tick(); req_valid = '0;
    run_until_resp(20);
    chk("sgn_div_signed", 64'(start_sgn_last), 64'(1));
    chk("sgn_resp_v",     64'(resp_v_first), 64'(4'b1000));
    chk("sgn_q",          64'(resp_q_first), 64'(32'hFFFF_FFF2));
    chk("sgn_r",          64'(resp_r_first), 64'(32'hFFFF_FFFE));

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 2500; n++) begin
      rst        = ($urandom_range(0, 199) == 0);
      mage       = ($urandom_range(0, 59) == 0);
      pea        = ($urandom_range(0, 4) != 0);
      req_valid  = 4'($urandom);
      resp_ready = 4'($urandom);
      req_sgn    = 4'($urandom);
      dv_lat     = $urandom_range(1, 6);
      for (int i = 0; i < N; i++) begin
        req_a[i] = $urandom;
        if ($urandom_range(0, 7) == 0) req_b[i] = '0;
        else if ($urandom_range(0, 1) == 1) req_b[i] = $urandom;
        else req_b[i] = $urandom_range(1, 50);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/s_div_arbiter.md
S_DIV_ARBITER -- requirements
Module: s_div_arbiter

Interface
REQ-001 Parameter N_REQ, default 4; number of requesting PEs sharing one divider, 2..8.
REQ-002 Parameter N_BITS, default pea_pkg::N_BITS; operand and result width.
REQ-003 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  in  1  synchronous, active-high reset.
REQ-005 mage_done_i  in  1  kernel end; flushes the block.
REQ-006 pea_ready_i  in  1  global array stall; 0 freezes the arbiter.
REQ-007 req_valid_i  in  N_REQ  per-PE division request.
REQ-008 req_a_i  in  N_REQ x N_BITS  per-PE dividend.
REQ-009 req_b_i  in  N_REQ x N_BITS  per-PE divisor.
REQ-010 req_signed_i  in  N_REQ  per-PE signed flag (1 = signed).
REQ-011 req_ready_o  out  N_REQ  one-hot grant; request accepted when valid and ready are both 1.
REQ-012 resp_valid_o  out  N_REQ  one-hot response valid to the owning PE.
REQ-013 resp_ready_i  in  N_REQ  per-PE response accept.
REQ-014 resp_q_o / resp_r_o  out  N_BITS each  broadcast quotient and remainder.
REQ-015 div_start_o  out  1  one-cycle start pulse to the shared divider.
REQ-016 div_abort_o  out  1  one-cycle abort pulse to the shared divider.
REQ-017 div_a_o / div_b_o / div_signed_o  out  N_BITS / N_BITS / 1  latched operands, stable from start until done.
REQ-018 div_done_i  in  1  divider result valid, single-cycle pulse.
REQ-019 div_q_i / div_r_i  in  N_BITS each  divider results.

Function
REQ-020 FSM states SHALL be IDLE, ISSUE, WAIT and RESP.
REQ-021 IDLE: when any req_valid_i is 1 and pea_ready_i is 1, the block asserts req_ready_o for one PE, latches its operands and id, and goes to ISSUE; if b = 0 it goes to RESP instead.
REQ-022 Grant selection: round-robin search from rr_ptr upward with wrap at N_REQ; first valid index wins.
REQ-023 ISSUE: div_start_o = 1 for exactly one cycle; go to WAIT; div_done_i is ignored in ISSUE.
REQ-024 WAIT: on div_done_i, latch div_q_i and div_r_i and go to RESP; no timeout.
REQ-025 RESP: resp_valid_o[id] = 1 and results held stable; when resp_ready_i[id] and pea_ready_i are both 1, go to IDLE and set rr_ptr = (id+1) mod N_REQ.
REQ-026 Divide by zero: the divider is bypassed; q = all ones; r = dividend; RESP is reached the cycle after the grant.
REQ-027 pea_ready_i = 0: state, rr_ptr and latches are held; req_ready_o = 0; div_start_o is suppressed and ISSUE is held.
REQ-028 In WAIT, div_done_i is captured even while pea_ready_i = 0, because the divider does not stall.
REQ-029 Minimum latency, grant to resp_valid: 2 cycles + divider latency, measured as grant, then start, then done, then RESP the next cycle.
REQ-030 At most one transaction is in flight; req_ready_o SHALL be 0 outside IDLE.
REQ-031 mage_done_i = 1 in any state: next state is IDLE, rr_ptr = 0, and all latches are cleared.
REQ-032 If mage_done_i arrives in ISSUE or WAIT, div_abort_o pulses for one cycle; mage_done_i has priority over every other event.
REQ-033 A div_done_i coinciding with mage_done_i SHALL be discarded.
REQ-034 req_ready_o, resp_valid_o, div_start_o and div_abort_o SHALL be combinational decodes of state; all data outputs SHALL be registered.

Reset
REQ-035 rst_i: state = IDLE, rr_ptr = 0, and all latched operands and results = 0.
REQ-036 All outputs SHALL be 0 during and after reset.
REQ-037 Reset mid-transaction SHALL NOT pulse div_abort_o; the divider is reset by the same rst_i.

Structure
REQ-038 pea_pkg SHALL hold div_arb_state_t (IDLE, ISSUE, WAIT, RESP) and N_DIV_REQ.
REQ-039 Round-robin grant logic SHALL be a sub-module rr_arbiter with inputs req, ptr and en, and outputs gnt_onehot and gnt_idx.

Verification
REQ-040 Single request: PE1 requests 100/7 unsigned, divider latency 4 -> grant cycle 0, start cycle 1, resp_valid_o = 0010 cycle 6, q = 14, r = 2.
REQ-041 Contention: all 4 PEs request continuously from reset -> grant order 0,1,2,3,0.
REQ-042 Divide by zero: PE2 requests 55/0 -> resp cycle 1, q = 0xFFFFFFFF, r = 55, div_start_o never asserted.
REQ-043 Stall: pea_ready_i = 0 in ISSUE for 3 cycles -> div_start_o is delayed 3 cycles; pea_ready_i = 0 in RESP -> handshake is held until ready.
REQ-044 Flush: mage_done_i during WAIT -> div_abort_o pulses once, state = IDLE next cycle, a later div_done_i is ignored, and rr_ptr = 0.
REQ-045 Signed: PE3 requests -100/7 with signed = 1 -> div_signed_o = 1 and the result from the divider model is forwarded unchanged: q = -14, r = -2.
